// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit HD44780-style LCD bus: command opcodes, FSM states and DDRAM layout.
package lcd_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned LINE_W   = 128;

    localparam logic [BYTE_W-1:0] LCD_CLEAR = 8'h01;
    localparam logic [BYTE_W-1:0] LCD_HOME  = 8'h02;
    localparam logic [BYTE_W-1:0] LCD_ENTRY = 8'h04;
    localparam logic [BYTE_W-1:0] LCD_DISP  = 8'h08;
    localparam logic [BYTE_W-1:0] LCD_SHIFT = 8'h10;
    localparam logic [BYTE_W-1:0] LCD_FUNC  = 8'h20;
    localparam logic [BYTE_W-1:0] LCD_CGRAM = 8'h40;
    localparam logic [BYTE_W-1:0] LCD_DDRAM = 8'h80;

    // Byte seen in 8-bit mode during the wake-up sequence
    localparam logic [BYTE_W-1:0] INIT_BYTE8 = 8'h30;

    localparam logic [ADDR_W-1:0] LINE1_BASE     = 7'h00;
    localparam logic [ADDR_W-1:0] LINE2_BASE_DEF = 7'h40;
    localparam logic [ADDR_W-1:0] LINE_SPAN_LAST = 7'h27;

    typedef enum logic [1:0] {
        ST_INIT8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } bus_state_e;

    // Cursor step over the two 40-byte line windows, wrapping line1 <-> line2
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic              inc,
                                                    input logic [ADDR_W-1:0] base2);
        logic [ADDR_W-1:0] end2;
        end2 = base2 + LINE_SPAN_LAST;
        if (inc) begin
            if (a == LINE_SPAN_LAST)  return base2;
            else if (a == end2)       return LINE1_BASE;
            else                      return a + 7'd1;
        end else begin
            if (a == LINE1_BASE)      return end2;
            else if (a == base2)      return LINE_SPAN_LAST;
            else                      return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Input synchroniser for the LCD bus pins plus falling-edge detect on the synced enable strobe.
module lcd_bus_sync
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lcd_e,
    input  logic                lcd_rs,
    input  logic                lcd_w,
    input  logic [NIBBLE_W-1:0] data,
    output logic                rs_s,
    output logic                w_s,
    output logic [NIBBLE_W-1:0] data_s,
    output logic                fall_c
);

    localparam int unsigned BUS_W = NIBBLE_W + 3;

    logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q, sync_d;
    logic                              e_prev_q, e_prev_d;
    logic [BUS_W-1:0]                  last;

    // All pins share the same depth so rs/w/data line up with the synced strobe
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], {lcd_e, lcd_rs, lcd_w, data}};
        e_prev_d = sync_q[SYNC_STAGES-1][BUS_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            e_prev_q <= e_prev_d;
        end
    end

    assign last   = sync_q[SYNC_STAGES-1];
    assign rs_s   = last[BUS_W-2];
    assign w_s    = last[BUS_W-3];
    assign data_s = last[NIBBLE_W-1:0];
    assign fall_c = e_prev_q & ~last[BUS_W-1];

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder end of the 4-bit LCD bus: rebuilds bytes, runs the 8->4-bit handshake and keeps a 2x16 DDRAM image.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] CLEAR_CHAR  = 8'h20,
    parameter logic [ADDR_W-1:0] LINE2_BASE  = LINE2_BASE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lcd_e,
    input  logic                lcd_rs,
    input  logic                lcd_w,
    input  logic [NIBBLE_W-1:0] data,
    output logic [LINE_W-1:0]   line1,
    output logic [LINE_W-1:0]   line2,
    output logic                byte_valid,
    output logic [BYTE_W-1:0]   byte_out,
    output logic                byte_is_data,
    output logic                mode4,
    output logic                disp_on,
    output logic                rd_ignored
);

    logic [1:0]                rst_sync_q, rst_sync_d;
    logic                      rst_i;
    logic                      rs_s, w_s, fall_c;
    logic [NIBBLE_W-1:0]       data_s;

    bus_state_e                state_q, state_d;
    logic [NIBBLE_W-1:0]       hi_q, hi_d;
    logic                      rs_hi_q, rs_hi_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      inc_q, inc_d;
    logic [15:0][BYTE_W-1:0]   line1_q, line1_d, line2_q, line2_d;
    logic                      byte_valid_q, byte_valid_d;
    logic [BYTE_W-1:0]         byte_out_q, byte_out_d;
    logic                      byte_is_data_q, byte_is_data_d;
    logic                      mode4_q, mode4_d;
    logic                      disp_on_q, disp_on_d;
    logic                      rd_ignored_q, rd_ignored_d;

    logic                      exec, exec_rs;
    logic [BYTE_W-1:0]         exec_byte;
    logic [ADDR_W-1:0]         line2_off;

    // Reset asserts immediately, releases on a clock edge
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= rst_sync_d;
    end
    assign rst_i = rst_sync_q[1];

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst_i),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_w  (lcd_w),
        .data   (data),
        .rs_s   (rs_s),
        .w_s    (w_s),
        .data_s (data_s),
        .fall_c (fall_c)
    );

    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        rs_hi_d        = rs_hi_q;
        addr_d         = addr_q;
        inc_d          = inc_q;
        line1_d        = line1_q;
        line2_d        = line2_q;
        byte_valid_d   = 1'b0;
        byte_out_d     = byte_out_q;
        byte_is_data_d = byte_is_data_q;
        mode4_d        = mode4_q;
        disp_on_d      = disp_on_q;
        rd_ignored_d   = 1'b0;
        exec           = 1'b0;
        exec_rs        = 1'b0;
        exec_byte      = 8'h00;
        line2_off      = addr_q - LINE2_BASE;

        if (fall_c) begin
            if (w_s) begin
                rd_ignored_d = 1'b1;
            end else begin
                case (state_q)
                    ST_INIT8: begin
                        exec_byte      = {data_s, 4'h0};
                        byte_valid_d   = 1'b1;
                        byte_out_d     = exec_byte;
                        byte_is_data_d = rs_s;
                        if (exec_byte == LCD_FUNC) begin
                            mode4_d = 1'b1;
                            state_d = ST_HI;
                        end else if (exec_byte != INIT_BYTE8) begin
                            exec = 1'b1;
                        end
                    end
                    ST_HI: begin
                        hi_d    = data_s;
                        rs_hi_d = rs_s;
                        state_d = ST_LO;
                    end
                    ST_LO: begin
                        exec_byte      = {hi_q, data_s};
                        exec_rs        = rs_hi_q;
                        exec           = 1'b1;
                        byte_valid_d   = 1'b1;
                        byte_out_d     = exec_byte;
                        byte_is_data_d = rs_hi_q;
                        state_d        = ST_HI;
                    end
                    default: state_d = ST_INIT8;
                endcase
            end
        end

        // Column 0 sits in the top byte of each line, hence the inverted column index
        if (exec) begin
            if (exec_rs) begin
                if (addr_q[6:4] == 3'd0) begin
                    line1_d[4'(~addr_q[3:0])] = exec_byte;
                end else if (line2_off[6:4] == 3'd0) begin
                    line2_d[4'(~line2_off[3:0])] = exec_byte;
                end
                addr_d = next_addr(addr_q, inc_q, LINE2_BASE);
            end else if ((exec_byte & LCD_DDRAM) != 8'h00) begin
                addr_d = exec_byte[6:0];
            end else if ((exec_byte & (LCD_CGRAM | LCD_FUNC | LCD_SHIFT)) != 8'h00) begin
                addr_d = addr_q;
            end else if ((exec_byte & LCD_DISP) != 8'h00) begin
                disp_on_d = exec_byte[2];
            end else if ((exec_byte & LCD_ENTRY) != 8'h00) begin
                inc_d = exec_byte[1];
            end else if ((exec_byte & LCD_HOME) != 8'h00) begin
                addr_d = LINE1_BASE;
            end else if ((exec_byte & LCD_CLEAR) != 8'h00) begin
                line1_d = {16{CLEAR_CHAR}};
                line2_d = {16{CLEAR_CHAR}};
                addr_d  = LINE1_BASE;
                inc_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_INIT8;
            hi_q           <= '0;
            rs_hi_q        <= 1'b0;
            addr_q         <= LINE1_BASE;
            inc_q          <= 1'b1;
            line1_q        <= {16{CLEAR_CHAR}};
            line2_q        <= {16{CLEAR_CHAR}};
            byte_valid_q   <= 1'b0;
            byte_out_q     <= '0;
            byte_is_data_q <= 1'b0;
            mode4_q        <= 1'b0;
            disp_on_q      <= 1'b0;
            rd_ignored_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            rs_hi_q        <= rs_hi_d;
            addr_q         <= addr_d;
            inc_q          <= inc_d;
            line1_q        <= line1_d;
            line2_q        <= line2_d;
            byte_valid_q   <= byte_valid_d;
            byte_out_q     <= byte_out_d;
            byte_is_data_q <= byte_is_data_d;
            mode4_q        <= mode4_d;
            disp_on_q      <= disp_on_d;
            rd_ignored_q   <= rd_ignored_d;
        end
    end

    assign line1        = line1_q;
    assign line2        = line2_q;
    assign byte_valid   = byte_valid_q;
    assign byte_out     = byte_out_q;
    assign byte_is_data = byte_is_data_q;
    assign mode4        = mode4_q;
    assign disp_on      = disp_on_q;
    assign rd_ignored   = rd_ignored_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed steps plus random traffic against a cursor/screen model.
module tb_lcd_bus_receiver;

    logic         clk = 1'b0;
    logic         rst, lcd_e, lcd_rs, lcd_w;
    logic [3:0]   data;
    logic [127:0] line1, line2;
    logic         byte_valid, byte_is_data, mode4, disp_on, rd_ignored;
    logic [7:0]   byte_out;

    lcd_bus_receiver dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_w(lcd_w), .data(data),
        .line1(line1), .line2(line2), .byte_valid(byte_valid), .byte_out(byte_out),
        .byte_is_data(byte_is_data), .mode4(mode4), .disp_on(disp_on), .rd_ignored(rd_ignored)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int rd_cnt = 0;
    logic [8:0] bq[$];

    // Pulse monitor: every byte_valid cycle is one reported byte
    always @(negedge clk) begin
        if (byte_valid) bq.push_back({byte_is_data, byte_out});
        if (rd_ignored) rd_cnt++;
    end

    // Model: screen as 80 linear cursor positions, 16 visible per line
    logic [7:0] m1[16];
    logic [7:0] m2[16];
    int         m_pos;
    bit         m_inc, m_disp, m_mode4, m_init8;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m1[i] = 8'h20; m2[i] = 8'h20; end
        m_pos = 0; m_inc = 1; m_disp = 0; m_mode4 = 0; m_init8 = 1;
    endtask

    function automatic int addr_to_pos(input int a);
        return (a >= 'h40) ? (a - 'h40 + 40) : a;
    endfunction

    task automatic model_exec(input logic [7:0] b, input bit is_data);
        if (is_data) begin
            if (m_pos < 16) m1[m_pos] = b;
            else if (m_pos >= 40 && m_pos < 56) m2[m_pos - 40] = b;
            m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
        end else if (b >= 8'h80) m_pos = addr_to_pos(int'(b[6:0]));
        else if (b >= 8'h10) begin end
        else if (b >= 8'h08) m_disp = b[2];
        else if (b >= 8'h04) m_inc = b[1];
        else if (b >= 8'h02) m_pos = 0;
        else if (b == 8'h01) begin
            for (int i = 0; i < 16; i++) begin m1[i] = 8'h20; m2[i] = 8'h20; end
            m_pos = 0; m_inc = 1;
        end
    endtask

    function automatic logic [127:0] pack_line(input bit second);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[127 - 8*c -: 8] = second ? m2[c] : m1[c];
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_nibble(input bit rs, input bit w, input logic [3:0] n);
        lcd_rs = rs; lcd_w = w; data = n;
        repeat (2) @(negedge clk);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_byte(input string tag, input logic [8:0] exp);
        check({tag, "_count"}, 128'(bq.size()), 128'd1);
        if (bq.size() > 0) check(tag, 128'(bq.pop_front()), 128'(exp));
        bq.delete();
    endtask

    // One bus transfer: a single nibble while in 8-bit wake-up, otherwise two
    task automatic xfer(input string tag, input logic [7:0] b, input bit rs);
        logic [7:0] got;
        if (m_init8) begin
            send_nibble(rs, 1'b0, b[7:4]);
            got = {b[7:4], 4'h0};
            if (got == 8'h20) begin m_mode4 = 1; m_init8 = 0; end
            else if (got != 8'h30) model_exec(got, 1'b0);
            expect_byte(tag, {rs, got});
        end else begin
            send_nibble(rs, 1'b0, b[7:4]);
            send_nibble(rs, 1'b0, b[3:0]);
            model_exec(b, rs);
            expect_byte(tag, {rs, b});
        end
    endtask

    task automatic check_screen(input string tag);
        check({tag, "_line1"}, line1, pack_line(1'b0));
        check({tag, "_line2"}, line2, pack_line(1'b1));
        check({tag, "_disp"}, 128'(disp_on), 128'(m_disp));
        check({tag, "_mode4"}, 128'(mode4), 128'(m_mode4));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        model_reset();
        bq.delete();
    endtask

    task automatic power_up(input string tag);
        xfer({tag, "_30a"}, 8'h30, 1'b0);
        xfer({tag, "_30b"}, 8'h30, 1'b0);
        xfer({tag, "_30c"}, 8'h30, 1'b0);
        check({tag, "_mode4_pre"}, 128'(mode4), 128'd0);
        xfer({tag, "_20"}, 8'h20, 1'b0);
        check({tag, "_mode4_post"}, 128'(mode4), 128'd1);
    endtask

    initial begin
        string hello;
        int    r0;
        rst = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_w = 1'b0; data = 4'h0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check("rst_line1", line1, {16{8'h20}});
        check("rst_line2", line2, {16{8'h20}});
        check("rst_flags", 128'({byte_valid, byte_out, byte_is_data, mode4, disp_on, rd_ignored}), 128'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bq.delete();

        power_up("init");

        xfer("cmd28", 8'h28, 1'b0);
        xfer("cmd06", 8'h06, 1'b0);
        xfer("cmd0c", 8'h0C, 1'b0);
        xfer("cmd01", 8'h01, 1'b0);
        check("disp_on", 128'(disp_on), 128'd1);
        check_screen("after_setup");

        hello = "HELLO WORLD 1234";
        xfer("cmd80", 8'h80, 1'b0);
        for (int i = 0; i < 16; i++) xfer("hello", 8'(hello[i]), 1'b1);
        check("hello_line1", line1, 128'("HELLO WORLD 1234"));
        xfer("cmdc0", 8'hC0, 1'b0);
        for (int i = 0; i < 16; i++) xfer("aaaa", 8'h41, 1'b1);
        check("aaaa_line2", line2, {16{8'h41}});

        // Invisible address 0x27 and wrap into line 2
        xfer("cmda7", 8'hA7, 1'b0);
        xfer("wr_x", 8'h58, 1'b1);
        xfer("wr_y", 8'h59, 1'b1);
        xfer("wr_w", 8'h57, 1'b1);
        check_screen("wrap27");

        // Decrement wraps 0x40 -> 0x27 and 0x00 -> 0x67
        xfer("cmd04", 8'h04, 1'b0);
        xfer("cmdc0b", 8'hC0, 1'b0);
        xfer("dec_a", 8'h61, 1'b1);
        xfer("dec_b", 8'h62, 1'b1);
        xfer("cmd80b", 8'h80, 1'b0);
        xfer("dec_c", 8'h63, 1'b1);
        xfer("dec_d", 8'h64, 1'b1);
        xfer("cmd06b", 8'h06, 1'b0);
        check_screen("decwrap");

        // Read strobe between the nibbles of one data byte
        r0 = rd_cnt;
        send_nibble(1'b1, 1'b0, 4'h5);
        send_nibble(1'b0, 1'b1, 4'hF);
        check("rd_pulse", 128'(rd_cnt - r0), 128'd1);
        check("rd_no_byte", 128'(bq.size()), 128'd0);
        send_nibble(1'b1, 1'b0, 4'h2);
        model_exec(8'h52, 1'b1);
        expect_byte("rd_byte", {1'b1, 8'h52});
        check_screen("rd");

        // Random traffic over visible and hidden cursor positions
        for (int k = 0; k < 160; k++) begin
            int op, p;
            op = int'($urandom_range(0, 19));
            if (op < 11) xfer("rnd_data", 8'($urandom_range(32, 126)), 1'b1);
            else if (op < 14) begin
                p = int'($urandom_range(0, 79));
                xfer("rnd_addr", 8'(8'h80 | (p < 40 ? p : p - 40 + 'h40)), 1'b0);
            end
            else if (op < 16) xfer("rnd_entry", 8'(8'h04 | $urandom_range(0, 3)), 1'b0);
            else if (op < 17) xfer("rnd_home", 8'(8'h02 | $urandom_range(0, 1)), 1'b0);
            else if (op < 19) xfer("rnd_disp", 8'(8'h08 | $urandom_range(0, 7)), 1'b0);
            else xfer("rnd_clear", 8'h01, 1'b0);
            if (k % 20 == 19) check_screen("rnd");
        end

        // Reset between the nibbles of 'Z'
        send_nibble(1'b1, 1'b0, 4'h5);
        do_reset();
        repeat (2) @(negedge clk);
        check("rstmid_bytes", 128'(bq.size()), 128'd0);
        check_screen("rstmid");
        power_up("reinit");
        xfer("post_q", 8'h51, 1'b1);
        check_screen("reinit");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
